// File: rtl/fpl_cfg_loader.sv
// fpl_cfg_loader: shadow configuration table for a programmable-logic fabric.
// The host fills a table of N_GATES*5 five-bit entries over the picosoc
// peripheral bus. A CTRL write then streams every entry to the fabric, one
// write per entry. Addresses 0x2000-0x2FFF are forwarded to the fabric
// whenever no commit is in progress.
// Optional feature: define FPL_CFG_AUTOLOAD_EN to start a commit of the
// all-zero table automatically in the first cycle after reset is released.
//
// Handshake: the host holds valid and addr/wdata/wstrb stable until ready.
// A request is taken when valid && !ready, and ready is a single-cycle pulse.
// A write has wstrb != 0 and a read has wstrb == 0. On the fabric side,
// f_valid and its payload stay asserted until the cycle in which f_ready is
// high, and f_valid drops in the cycle after that.
module fpl_cfg_loader #(
    parameter int N_GATES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    output logic        ready,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        f_valid,
    input  logic        f_ready,
    output logic [15:0] f_addr,
    output logic [31:0] f_wdata,
    output logic [3:0]  f_wstrb,
    input  logic [31:0] f_rdata,
    output logic        busy,
    output logic [1:0]  fsm_state
);
    localparam int         N_ENTRIES = N_GATES * 5;
    localparam logic [5:0] LAST_IDX  = 6'(N_ENTRIES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        PASS  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [4:0] shadow [N_ENTRIES];
    logic [5:0] idx;
    logic [2:0] cur_gate;
    logic [2:0] cur_reg;
    logic       done;

    logic       host_acc;
    logic       pass_hit;
    logic       ctrl_hit;
    logic       shadow_hit;
    logic [5:0] host_idx;
    logic [31:0] rd_val;
    logic       start_req;
    logic       auto_start;

    logic       do_start;
    logic       do_pass;
    logic       do_next;
    logic       do_done;

    logic [5:0] next_idx;
    logic [2:0] next_gate;
    logic [2:0] next_reg;

    // Host address decode; the shadow index is gate*5 + reg
    assign host_acc   = valid && !ready;
    assign pass_hit   = (addr[15:12] == 4'h2);
    assign ctrl_hit   = (addr == 16'h1000);
    assign host_idx   = 6'(addr[10:8]) * 6'd5 + 6'(addr[2:0]);
    assign shadow_hit = (addr[15:11] == 5'd0) && (addr[7:4] == 4'd0) &&
                        (addr[3:0] < 4'd5) && (host_idx <= LAST_IDX);

`ifdef FPL_CFG_AUTOLOAD_EN
    logic auto_pend;

    // Set during reset so that the first cycle after release requests a commit
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_pend <= 1'b1;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    assign auto_start = auto_pend;
`else
    assign auto_start = 1'b0;
`endif

    // A start from the host or the autoload both count; start beats passthrough
    assign start_req = (host_acc && ctrl_hit && wstrb[0] && wdata[0]) || auto_start;

    assign busy      = (state == ISSUE) || (state == GAP);
    assign fsm_state = state;

    // Read mux for the locally answered addresses
    always_comb begin
        rd_val = 32'd0;
        if (shadow_hit) begin
            rd_val = {27'd0, shadow[host_idx]};
        end else if (ctrl_hit) begin
            rd_val = {16'd0, 2'd0, idx, 6'd0, done, busy};
        end
    end

    // Entry walk order: reg 0..4 within a gate, then the next gate
    always_comb begin
        next_idx  = idx + 6'd1;
        next_gate = cur_gate;
        next_reg  = cur_reg + 3'd1;
        if (cur_reg == 3'd4) begin
            next_reg  = 3'd0;
            next_gate = cur_gate + 3'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and load strobes for the fabric-side registers
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_pass    = 1'b0;
        do_next    = 1'b0;
        do_done    = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) begin
                    state_next = ISSUE;
                    do_start   = 1'b1;
                end else if (host_acc && pass_hit) begin
                    state_next = PASS;
                    do_pass    = 1'b1;
                end
            end
            ISSUE: begin
                if (f_ready) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                    do_done    = 1'b1;
                end else begin
                    state_next = ISSUE;
                    do_next    = 1'b1;
                end
            end
            PASS: begin
                if (f_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fabric request registers, entry pointer and done flag
    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid  <= 1'b0;
            f_addr   <= 16'd0;
            f_wdata  <= 32'd0;
            f_wstrb  <= 4'd0;
            idx      <= 6'd0;
            cur_gate <= 3'd0;
            cur_reg  <= 3'd0;
            done     <= 1'b0;
        end else begin
            if (do_start) begin
                idx      <= 6'd0;
                cur_gate <= 3'd0;
                cur_reg  <= 3'd0;
                done     <= 1'b0;
                f_valid  <= 1'b1;
                f_addr   <= 16'd0;
                f_wdata  <= {27'd0, shadow[0]};
                f_wstrb  <= 4'b0001;
            end else if (do_next) begin
                idx      <= next_idx;
                cur_gate <= next_gate;
                cur_reg  <= next_reg;
                f_valid  <= 1'b1;
                f_addr   <= {5'd0, next_gate, 5'd0, next_reg};
                f_wdata  <= {27'd0, shadow[next_idx]};
                f_wstrb  <= 4'b0001;
            end else if (do_pass) begin
                f_valid  <= 1'b1;
                f_addr   <= {4'h0, addr[11:0]};
                f_wdata  <= wdata;
                f_wstrb  <= wstrb;
            end else if (do_done) begin
                done     <= 1'b1;
            end else if ((state == ISSUE || state == PASS) && f_ready) begin
                f_valid  <= 1'b0;
            end
        end
    end

    // Host responses: local accesses ack next cycle, passthrough acks after f_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            rdata <= 32'd0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                shadow[i] <= 5'd0;
            end
        end else begin
            ready <= 1'b0;
            if (host_acc && !pass_hit) begin
                ready <= 1'b1;
                rdata <= rd_val;
                if (shadow_hit && wstrb[0]) begin
                    shadow[host_idx] <= wdata[4:0];
                end
            end else if (state == PASS && f_ready) begin
                ready <= 1'b1;
                rdata <= f_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fpl_cfg_loader.sv
// tb_fpl_cfg_loader: randomized bench for fpl_cfg_loader.
// The reference model is a plain array holding the shadow table. A commit is
// predicted as the full list of entries in index order, and a passthrough as
// one forwarded access. Both predictions go into expected queues that
// independent monitors drain. Build with FPL_CFG_AUTOLOAD_EN defined to also
// expect the automatic commit after every reset.
module tb_fpl_cfg_loader;
    localparam int N_GATES = 8;
    localparam int N_ENT   = N_GATES * 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [15:0] addr = 16'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] rdata;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [15:0] f_addr;
    logic [31:0] f_wdata;
    logic [3:0]  f_wstrb;
    logic [31:0] f_rdata = 32'd0;
    logic        busy;
    logic [1:0]  fsm_state;

    fpl_cfg_loader #(.N_GATES(N_GATES)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .ready     (ready),
        .addr      (addr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_addr    (f_addr),
        .f_wdata   (f_wdata),
        .f_wstrb   (f_wstrb),
        .f_rdata   (f_rdata),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Fabric that answers f_ready one cycle after f_valid rises
    always @(posedge clk) f_ready <= (f_valid === 1'b1) && !f_ready;

    // Expected queues: host item {is_read, pass, mask[31:0], data[31:0]},
    // fabric item {commit, addr[15:0], data[31:0], strb[3:0]}
    logic [65:0] host_q[$];
    logic [52:0] fab_q[$];

    // Reference model
    logic [4:0] shadow_m [N_ENT];
    int         m_idx = 0;
    bit         m_done = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int fab_count = 0;
    int last_fready_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [15:0] ent_addr(input int i);
        return 16'((i / 5) * 256 + (i % 5));
    endfunction

    function automatic logic [31:0] ctrl_exp();
        return {16'd0, 2'd0, 6'(m_idx), 6'd0, m_done, 1'b0};
    endfunction

    // Host monitor: every ready pulse consumes one expected host item
    logic [65:0] host_item;
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (host_q.size() == 0) begin
                fail_now("host_unexpected_ready", $sformatf("ready with rdata 0x%0h, no access outstanding", rdata));
            end else begin
                host_item = host_q.pop_front();
                if (host_item[65]) check("host_rdata", rdata & host_item[63:32], host_item[31:0] & host_item[63:32]);
                if (host_item[64]) check("pass_ready_latency", cyc, last_fready_cyc + 1);
            end
        end
    end

    // Fabric monitor: every completed fabric write consumes one expected item
    logic [52:0] fab_item;
    always @(negedge clk) begin
        if (f_valid === 1'b1 && f_ready === 1'b1) begin
            fab_count++;
            last_fready_cyc = cyc;
            if (fab_q.size() == 0) begin
                fail_now("fab_unexpected", $sformatf("addr 0x%0h data 0x%0h, none expected", f_addr, f_wdata));
            end else begin
                fab_item = fab_q.pop_front();
                check("fab_write", {f_addr, f_wdata, f_wstrb}, fab_item[51:0]);
            end
        end
    end

    // Driver: one host access, bounded wait for ready
    task automatic host_access(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ready !== 1'b1 && n < 2000);
        if (ready !== 1'b1) fail_now("host_timeout", $sformatf("no ready for addr 0x%0h, expected within 2000 cycles", a));
        valid = 1'b0; wstrb = 4'd0;
    endtask

    task automatic host_read(input logic [15:0] a, input logic [31:0] exp, input logic [31:0] mask);
        host_q.push_back({1'b1, 1'b0, mask, exp});
        host_access(a, 32'd0, 4'd0);
    endtask

    task automatic shadow_write(input int i, input logic [31:0] d, input logic [3:0] s);
        logic [52:0] t;
        host_q.push_back({2'b00, 64'd0});
        if (s[0]) begin
            shadow_m[i] = d[4:0];
            foreach (fab_q[k]) begin
                t = fab_q[k];
                if (t[52] && t[51:36] == ent_addr(i)) begin
                    t[35:4] = {27'd0, d[4:0]};
                    fab_q[k] = t;
                end
            end
        end
        host_access(ent_addr(i), d, s);
    endtask

    task automatic ctrl_start(input bit expect_commit);
        host_q.push_back({2'b00, 64'd0});
        if (expect_commit) begin
            for (int i = 0; i < N_ENT; i++) fab_q.push_back({1'b1, ent_addr(i), 27'd0, shadow_m[i], 4'b0001});
            m_done = 1'b0;
            m_idx  = 0;
        end
        host_access(16'h1000, {$urandom} | 32'd1, 4'b0001);
    endtask

    task automatic pass_access(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] frd);
        f_rdata = frd;
        fab_q.push_back({1'b0, 4'h0, a[11:0], d, s});
        host_q.push_back({1'b1, 1'b1, 32'hFFFF_FFFF, frd});
        host_access(a, d, s);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) fail_now(name, "busy still high after 5000 cycles, expected 0");
        m_done = 1'b1;
        m_idx  = N_ENT - 1;
    endtask

    // Reset: checks the cleared outputs, flushes expectations, models the table clear
    task automatic do_reset();
        int c0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_f_valid", f_valid, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_f_addr", f_addr, 0);
        check("rst_f_wdata", f_wdata, 0);
        check("rst_f_wstrb", f_wstrb, 0);
        check("rst_rdata", rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        fab_q.delete();
        host_q.delete();
        for (int i = 0; i < N_ENT; i++) shadow_m[i] = 5'd0;
        m_idx = 0;
        m_done = 1'b0;
        c0 = fab_count;
`ifdef FPL_CFG_AUTOLOAD_EN
        for (int i = 0; i < N_ENT; i++) fab_q.push_back({1'b1, ent_addr(i), 32'd0, 4'b0001});
        rst = 1'b0;
        @(posedge clk); #1;
        check("autoload_busy", busy, 1);
        wait_idle("autoload_timeout");
        check("autoload_writes", fab_count - c0, N_ENT);
`else
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("idle_after_reset_busy", busy, 0);
        check("idle_after_reset_writes", fab_count - c0, 0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        int e;
        logic [31:0] d;

        do_reset();

        // Control and table after reset
        host_read(16'h1000, ctrl_exp(), 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            e = $urandom_range(0, N_ENT - 1);
            host_read(ent_addr(e), 32'd0, 32'hFFFF_FFFF);
        end

        // Fill the table with random values, random byte strobes
        for (int i = 0; i < N_ENT; i++) begin
            d = $urandom;
            if (i == 17) shadow_write(i, 32'h0000_0013, 4'b1111);
            else shadow_write(i, d, 4'($urandom_range(0, 15)));
        end
        for (int k = 0; k < 8; k++) begin
            e = $urandom_range(0, N_ENT - 1);
            host_read(ent_addr(e), {27'd0, shadow_m[e]}, 32'hFFFF_FFFF);
        end
        host_read(16'h0302, 32'h0000_0013, 32'hFFFF_FFFF);

        // Unmapped addresses: writes dropped, reads zero
        host_q.push_back({2'b00, 64'd0}); host_access(16'h0005, 32'h1F, 4'b1111);
        host_q.push_back({2'b00, 64'd0}); host_access(16'h0015, 32'h1F, 4'b1111);
        host_q.push_back({2'b00, 64'd0}); host_access(16'h0810, 32'h1F, 4'b1111);
        host_q.push_back({2'b00, 64'd0}); host_access(16'h3000, 32'h1F, 4'b1111);
        host_read(16'h0005, 32'd0, 32'hFFFF_FFFF);
        host_read(16'h0810, 32'd0, 32'hFFFF_FFFF);
        host_read(16'h3000, 32'd0, 32'hFFFF_FFFF);
        host_read(16'h1004, 32'd0, 32'hFFFF_FFFF);
        host_read(16'h0100, {27'd0, shadow_m[5]}, 32'hFFFF_FFFF);
        host_read(16'h0000, {27'd0, shadow_m[0]}, 32'hFFFF_FFFF);

        // Full commit with cycle count
        c0 = fab_count;
        ctrl_start(1'b1);
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        @(posedge clk); #1;
        m_done = 1'b1;
        m_idx = N_ENT - 1;
        check("commit_cycles", n, N_ENT * 3);
        check("commit_writes", fab_count - c0, N_ENT);
        check("commit_drained", fab_q.size(), 0);
        host_read(16'h1000, ctrl_exp(), 32'hFFFF_FFFF);

        // Passthrough while idle
        pass_access(16'h2000, 32'd0, 4'd0, 32'hABCD1234);
        for (int k = 0; k < 4; k++) begin
            pass_access(16'h2000 | 16'($urandom_range(0, 4095)), $urandom, 4'($urandom_range(0, 15)), $urandom);
        end
        check("pass_drained", fab_q.size(), 0);

        // Passthrough stalled behind a commit, issued around entry 10
        c0 = fab_count;
        ctrl_start(1'b1);
        repeat (30) @(posedge clk);
        #1;
        pass_access(16'h2000, $urandom, 4'd0, $urandom);
        check("stall_busy_done", busy, 0);
        check("stall_writes", fab_count - c0, N_ENT + 1);
        m_done = 1'b1;
        m_idx = N_ENT - 1;
        host_read(16'h1000, ctrl_exp(), 32'hFFFF_FFFF);

        // Table writes during a commit: issued entry keeps old value, pending one takes new
        c0 = fab_count;
        ctrl_start(1'b1);
        repeat (15) @(posedge clk);
        #1;
        shadow_write(0, {27'd0, 5'(shadow_m[0] ^ 5'h15)}, 4'b0001);
        shadow_write(35, {27'd0, 5'(shadow_m[35] ^ 5'h0A)}, 4'b0001);
        wait_idle("midwrite_timeout");
        check("midwrite_writes", fab_count - c0, N_ENT);
        check("midwrite_drained", fab_q.size(), 0);

        // Second start while busy is acked and ignored
        c0 = fab_count;
        ctrl_start(1'b1);
        repeat (5) @(posedge clk);
        #1;
        ctrl_start(1'b0);
        host_read(16'h1000, 32'h0000_0001, 32'h0000_0003);
        wait_idle("double_start_timeout");
        check("double_start_writes", fab_count - c0, N_ENT);
        host_read(16'h1000, ctrl_exp(), 32'hFFFF_FFFF);

        // Reset around entry 20 aborts the commit
        ctrl_start(1'b1);
        repeat (60) @(posedge clk);
        #1;
        do_reset();
        host_read(16'h1000, ctrl_exp(), 32'hFFFF_FFFF);
        host_read(16'h0302, 32'd0, 32'hFFFF_FFFF);

        // Commit of the cleared table
        c0 = fab_count;
        ctrl_start(1'b1);
        wait_idle("zero_commit_timeout");
        check("zero_commit_writes", fab_count - c0, N_ENT);

        repeat (5) @(posedge clk);
        check("final_fab_q", fab_q.size(), 0);
        check("final_host_q", host_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
